// File: rtl/srio_arb_pkg.sv
// Shared types and defaults for the SRIO request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package srio_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_t;

  // Cycles the SRIO status pair must stay high before link_up asserts.
  localparam int LINK_STABLE_DEF = 16;

endpackage

// File: rtl/srio_link_debounce.sv
// Debounces the SRIO core status pair into a single link_up flag.
// Latency: link_up rises LINK_STABLE cycles after both inputs go high; falls one cycle after either drops.
// Backpressure: none (status path only).
//
// Ports:
//   sys_clk, sys_rst_n                   clock, async active-low reset
//   port_initialized, link_initialized   raw SRIO status (sys_clk domain)
//   link_up                              registered, debounced link status
module srio_link_debounce
  import srio_arb_pkg::*;
#(
  parameter int LINK_STABLE = LINK_STABLE_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic port_initialized,
  input  logic link_initialized,
  output logic link_up
);

  localparam int CNT_W = (LINK_STABLE > 1) ? $clog2(LINK_STABLE) : 1;

  logic [CNT_W-1:0] stable_cnt;
  logic             status_ok;

  assign status_ok = port_initialized & link_initialized;

  // The counter saturates at LINK_STABLE-1; the cycle the last high sample
  // arrives is the one that sets link_up. Any low sample clears both.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable_cnt <= '0;
      link_up    <= 1'b0;
    end else if (!status_ok) begin
      stable_cnt <= '0;
      link_up    <= 1'b0;
    end else if (stable_cnt == CNT_W'(LINK_STABLE - 1)) begin
      link_up    <= 1'b1;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/srio_req_arbiter.sv
// Two-requester packet arbiter feeding the SRIO ireq stream, round-robin at packet granularity.
// Latency: grant registered one cycle after request in IDLE; data path combinational while BUSY; one idle bubble between packets.
// Backpressure: m_tready passes straight to the owner's s_tready; non-owner held (tready=0) until next arbitration.
//
// Ports:
//   sys_clk, sys_rst_n                     clock, async active-low reset
//   port_initialized, link_initialized     SRIO core status
//   s0_t*/s1_t*                            requester streams (valid/ready/data/keep/last)
//   m_t*                                   SRIO ireq stream
//   grant                                  one-hot packet owner, 0 when none
//   link_up                                debounced link status
//   pkt_cnt0/pkt_cnt1/flush_cnt            statistics, present only with SRIO_ARB_STATS_EN
module srio_req_arbiter
  import srio_arb_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int LINK_STABLE = LINK_STABLE_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                port_initialized,
  input  logic                link_initialized,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [DATA_W-1:0]   s0_tdata,
  input  logic [DATA_W/8-1:0] s0_tkeep,
  input  logic                s0_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  input  logic [DATA_W-1:0]   s1_tdata,
  input  logic [DATA_W/8-1:0] s1_tkeep,
  input  logic                s1_tlast,
  output logic                m_tvalid,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic [1:0]          grant,
  output logic                link_up
`ifdef SRIO_ARB_STATS_EN
  ,
  output logic [31:0]         pkt_cnt0,
  output logic [31:0]         pkt_cnt1,
  output logic [15:0]         flush_cnt
`endif
);

  arb_state_t state, state_nxt;
  logic [1:0] grant_nxt;
  // High when s1 wins the next two-way contention.
  logic       rr_next_s1, rr_nxt;

  logic                owner_s1;
  logic                own_vld;
  logic [DATA_W-1:0]   own_dat;
  logic [DATA_W/8-1:0] own_keep;
  logic                own_last;

  srio_link_debounce #(
    .LINK_STABLE (LINK_STABLE)
  ) u_debounce (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .port_initialized (port_initialized),
    .link_initialized (link_initialized),
    .link_up          (link_up)
  );

  assign owner_s1 = grant[1];
  assign own_vld  = owner_s1 ? s1_tvalid : s0_tvalid;
  assign own_dat  = owner_s1 ? s1_tdata  : s0_tdata;
  assign own_keep = owner_s1 ? s1_tkeep  : s0_tkeep;
  assign own_last = owner_s1 ? s1_tlast  : s0_tlast;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_next_s1;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      ST_DOWN: begin
        grant_nxt = 2'b00;
        if (link_up) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!link_up) begin
          state_nxt = ST_DOWN;
        end else if (s0_tvalid && s1_tvalid) begin
          grant_nxt = rr_next_s1 ? 2'b10 : 2'b01;
          state_nxt = ST_BUSY;
        end else if (s0_tvalid) begin
          grant_nxt = 2'b01;
          state_nxt = ST_BUSY;
        end else if (s1_tvalid) begin
          grant_nxt = 2'b10;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!link_up) begin
          // Output is cut the cycle the link drops; the owner drains in FLUSH.
          state_nxt = ST_FLUSH;
        end else begin
          m_tvalid  = own_vld;
          if (own_vld) begin
            m_tdata = own_dat;
            m_tkeep = own_keep;
            m_tlast = own_last;
          end
          s0_tready = !owner_s1 && m_tready;
          s1_tready =  owner_s1 && m_tready;
          if (own_vld && m_tready && own_last) begin
            state_nxt = ST_IDLE;
            grant_nxt = 2'b00;
            rr_nxt    = !owner_s1;
          end
        end
      end
      ST_FLUSH: begin
        s0_tready = !owner_s1;
        s1_tready =  owner_s1;
        if (own_vld && own_last) begin
          state_nxt = ST_DOWN;
          grant_nxt = 2'b00;
          rr_nxt    = !owner_s1;
        end
      end
      default: begin
        state_nxt = ST_DOWN;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_DOWN;
      grant      <= 2'b00;
      rr_next_s1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_next_s1 <= rr_nxt;
    end
  end

`ifdef SRIO_ARB_STATS_EN
  logic pkt_done, flush_enter;

  assign pkt_done    = (state == ST_BUSY) && m_tvalid && m_tready && m_tlast;
  assign flush_enter = (state == ST_BUSY) && !link_up;

  // Free-running counters; they wrap naturally at full scale.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      flush_cnt <= '0;
    end else begin
      if (pkt_done && !owner_s1) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (pkt_done &&  owner_s1) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      if (flush_enter)           flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_srio_req_arbiter.sv
// Self-checking bench for srio_req_arbiter: directed scenarios plus randomized traffic against a packet-level model.
// Latency: n/a.
// Backpressure: m_tready driven by the bench (patterned or random).
module tb_srio_req_arbiter;

  localparam int DATA_W    = 64;
  localparam int KW        = DATA_W / 8;
  localparam int LS        = 16;
  localparam int RND_BEATS = 48;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              port_initialized = 1'b0;
  logic              link_initialized = 1'b0;
  logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic              s0_tready, s1_tready;
  logic [DATA_W-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0]     s0_tkeep = '0, s1_tkeep = '0;
  logic              s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic              m_tvalid, m_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tready = 1'b0;
  logic [1:0]        grant;
  logic              link_up;
`ifdef SRIO_ARB_STATS_EN
  logic [31:0]       pkt_cnt0, pkt_cnt1;
  logic [15:0]       flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  srio_req_arbiter #(.DATA_W(DATA_W), .LINK_STABLE(LS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .port_initialized(port_initialized), .link_initialized(link_initialized),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .link_up(link_up)
`ifdef SRIO_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .flush_cnt(flush_cnt)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    s0_tdata = '0; s1_tdata = '0; s0_tkeep = '0; s1_tkeep = '0; m_tready = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; port_initialized = 1'b0; link_initialized = 1'b0;
    clear_inputs();
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
  endtask

  // Raise both status bits, wait for link_up, then one more edge to reach IDLE.
  task automatic bring_up();
    int t;
    t = 0;
    port_initialized = 1'b1; link_initialized = 1'b1;
    while (link_up !== 1'b1 && t < 4 * LS) begin step(); t++; end
    n_checks++;
    if (link_up !== 1'b1) begin n_fail++; $display("FAIL bring_up: link_up=%b expected 1 within %0d cycles", link_up, 4 * LS); end
    step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; port_initialized = 1'b1; link_initialized = 1'b1;
    s0_tvalid = 1'b1; s1_tvalid = 1'b1; s0_tdata = '1; m_tready = 1'b1;
    repeat (3) step();
    n_checks++; if (grant !== 2'b00)   begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_checks++; if (link_up !== 1'b0)  begin n_fail++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    n_checks++; if (m_tdata !== '0)    begin n_fail++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
    n_checks++; if ({s0_tready, s1_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_tready: got %b expected 00", {s0_tready, s1_tready}); end
`ifdef SRIO_ARB_STATS_EN
    n_checks++; if ({pkt_cnt0, pkt_cnt1, flush_cnt} !== '0) begin n_fail++; $display("FAIL reset_stats: got %h/%h/%h expected 0", pkt_cnt0, pkt_cnt1, flush_cnt); end
`endif
    clear_inputs();
    sys_rst_n = 1'b1;
  endtask

  // Model: link_up follows from the length of the current run of high status samples.
  task automatic test_link_debounce();
    int  run;
    logic exp;
    do_reset();
    run = 0;
    for (int c = 0; c < 64; c++) begin
      port_initialized = (c != 20);
      link_initialized = (c != 30);
      step();
      run = (port_initialized && link_initialized) ? run + 1 : 0;
      exp = (run >= LS);
      n_checks++;
      if (link_up !== exp) begin n_fail++; $display("FAIL debounce_c%0d: link_up=%b expected %b", c, link_up, exp); end
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d [4];
    logic [KW-1:0]     k [4];
    do_reset(); bring_up();
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin d[b] = {$urandom, $urandom}; k[b] = KW'($urandom); end
    s0_tvalid = 1'b1; s0_tdata = d[0]; s0_tkeep = k[0]; s0_tlast = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_idle_grant: got %b expected 00", grant); end
    n_checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0) begin n_fail++; $display("FAIL single_idle_out: vld=%b dat=%h keep=%h expected 0/0/0", m_tvalid, m_tdata, m_tkeep); end
    step();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant); end
    for (int b = 0; b < 4; b++) begin
      s0_tdata = d[b]; s0_tkeep = k[b]; s0_tlast = (b == 3);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== d[b] || m_tkeep !== k[b] || m_tlast !== (b == 3) || s0_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL single_beat%0d: vld=%b dat=%h keep=%h last=%b rdy=%b expected 1/%h/%h/%b/1",
                 b, m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, d[b], k[b], b == 3);
      end
      step();
    end
    s0_tvalid = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_after: grant=%b vld=%b expected 00/0", grant, m_tvalid); end
    clear_inputs();
  endtask

  // Model: with both always requesting and 2-beat packets, each 3-cycle slot is one
  // idle cycle followed by two owner beats, owners alternating starting with s0.
  task automatic test_contention();
    logic [DATA_W-1:0] sd [2][8];
    int bi [2];
    logic [1:0] exp_g;
    int o;
    logic f0, f1;
    do_reset(); bring_up();
    m_tready = 1'b1;
    for (int s = 0; s < 2; s++) begin bi[s] = 0; for (int i = 0; i < 8; i++) sd[s][i] = {$urandom, $urandom}; end
    s0_tkeep = '1; s1_tkeep = '1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      s0_tvalid = 1'b1; s0_tdata = sd[0][bi[0]]; s0_tlast = (bi[0] % 2 == 1);
      s1_tvalid = 1'b1; s1_tdata = sd[1][bi[1]]; s1_tlast = (bi[1] % 2 == 1);
      #1;
      exp_g = (cyc % 3 == 0) ? 2'b00 : (((cyc / 3) % 2 == 0) ? 2'b01 : 2'b10);
      n_checks++;
      if (grant !== exp_g) begin n_fail++; $display("FAIL contention_grant_c%0d: got %b expected %b", cyc, grant, exp_g); end
      if (exp_g != 2'b00) begin
        o = exp_g[1] ? 1 : 0;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== sd[o][bi[o]]) begin
          n_fail++; $display("FAIL contention_data_c%0d: vld=%b dat=%h expected 1/%h", cyc, m_tvalid, m_tdata, sd[o][bi[o]]);
        end
      end
      f0 = s0_tvalid & s0_tready; f1 = s1_tvalid & s1_tready;
      step();
      if (f0) bi[0]++;
      if (f1) bi[1]++;
    end
    n_checks++; if (bi[0] != 4 || bi[1] != 4) begin n_fail++; $display("FAIL contention_beats: s0=%0d s1=%0d expected 4/4", bi[0], bi[1]); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] sd [3];
    int bi, nacc;
    logic f1;
    do_reset(); bring_up();
    for (int i = 0; i < 3; i++) sd[i] = {$urandom, $urandom};
    bi = 0; nacc = 0; s1_tkeep = '1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      s1_tvalid = (bi < 3);
      s1_tdata  = sd[(bi < 3) ? bi : 2];
      s1_tlast  = (bi == 2);
      m_tready  = (cyc % 2 == 1);
      #1;
      if (cyc >= 1 && cyc <= 5) begin
        n_checks++;
        if (s1_tready !== m_tready || s0_tready !== 1'b0) begin
          n_fail++; $display("FAIL bp_tready_c%0d: s1_tready=%b s0_tready=%b expected %b/0", cyc, s1_tready, s0_tready, m_tready);
        end
      end
      if (m_tvalid && m_tready) begin
        n_checks++;
        if (nacc >= 3 || grant !== 2'b10 || m_tdata !== sd[(nacc < 3) ? nacc : 2] || m_tlast !== (nacc == 2)) begin
          n_fail++; $display("FAIL bp_beat%0d: grant=%b dat=%h last=%b expected 10/%h/%b", nacc, grant, m_tdata, m_tlast, sd[(nacc < 3) ? nacc : 2], nacc == 2);
        end
        nacc++;
      end
      f1 = s1_tvalid & s1_tready;
      step();
      if (f1) bi++;
    end
    n_checks++; if (nacc != 3 || bi != 3 || grant !== 2'b00) begin n_fail++; $display("FAIL bp_total: fwd=%0d taken=%0d grant=%b expected 3/3/00", nacc, bi, grant); end
    clear_inputs();
  endtask

  task automatic test_link_drop();
    logic [DATA_W-1:0] sd [5];
    int bi, nfwd;
    logic f0;
    do_reset(); bring_up();
    m_tready = 1'b1; s0_tkeep = '1;
    for (int i = 0; i < 5; i++) sd[i] = {$urandom, $urandom};
    bi = 0; nfwd = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      s0_tvalid = (bi < 5);
      s0_tdata  = sd[(bi < 5) ? bi : 4];
      s0_tlast  = (bi == 4);
      if (bi == 1) port_initialized = 1'b0;
      #1;
      if (!link_up) begin
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_mvalid_c%0d: got %b expected 0", cyc, m_tvalid); end
      end
      if (m_tvalid && m_tready) nfwd++;
      f0 = s0_tvalid & s0_tready;
      step();
      if (f0) bi++;
    end
    n_checks++; if (nfwd != 2) begin n_fail++; $display("FAIL drop_forwarded: got %0d expected 2", nfwd); end
    n_checks++; if (bi != 5)   begin n_fail++; $display("FAIL drop_consumed: got %0d expected 5", bi); end
    s1_tvalid = 1'b1; s1_tlast = 1'b1;
    step();
    n_checks++;
    if (grant !== 2'b00 || s1_tready !== 1'b0 || link_up !== 1'b0) begin
      n_fail++; $display("FAIL drop_down: grant=%b s1_tready=%b link_up=%b expected 00/0/0", grant, s1_tready, link_up);
    end
`ifdef SRIO_ARB_STATS_EN
    n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_flush_cnt: got %0d expected 1", flush_cnt); end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] d [2];
    do_reset(); bring_up();
    m_tready = 1'b1;
    s0_tvalid = 1'b1; s0_tdata = {$urandom, $urandom}; s0_tkeep = '1; s0_tlast = 1'b0;
    step(); step();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_pre_grant: got %b expected 01", grant); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || link_up !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== '0 || s0_tready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: grant=%b link=%b vld=%b dat=%h rdy=%b expected 00/0/0/0/0", grant, link_up, m_tvalid, m_tdata, s0_tready);
    end
    s0_tvalid = 1'b0;
    step();
    sys_rst_n = 1'b1;
    bring_up();
    d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
    s1_tvalid = 1'b1; s1_tdata = d[0]; s1_tkeep = '1; s1_tlast = 1'b0;
    step();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 10", grant); end
    for (int b = 0; b < 2; b++) begin
      s1_tdata = d[b]; s1_tlast = (b == 1);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== d[b] || m_tlast !== (b == 1)) begin
        n_fail++; $display("FAIL rstmid_beat%0d: vld=%b dat=%h last=%b expected 1/%h/%b", b, m_tvalid, m_tdata, m_tlast, d[b], b == 1);
      end
      step();
    end
    s1_tvalid = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_release: got %b expected 00", grant); end
    clear_inputs();
  endtask

  // Model: each source is an ordered beat list; every forwarded beat must be the owner's next
  // unsent beat, and a grant issued from an idle cycle follows the round-robin rule.
  task automatic test_random();
    logic [DATA_W-1:0] rd [2][RND_BEATS];
    logic [KW-1:0]     rk [2][RND_BEATS];
    logic              rl [2][RND_BEATS];
    logic              v [2];
    int si [2], ei [2], pkts [2];
    int cyc, o, j0, j1;
    logic rr_s1, exp_armed, f0, f1;
    logic [1:0] exp_g;
    do_reset(); bring_up();
    for (int s = 0; s < 2; s++) begin
      si[s] = 0; ei[s] = 0; pkts[s] = 0; v[s] = 1'b0;
      for (int i = 0; i < RND_BEATS; i++) begin
        rd[s][i] = {$urandom, $urandom};
        rk[s][i] = KW'($urandom);
        rl[s][i] = ($urandom_range(0, 2) == 0) || (i == RND_BEATS - 1);
      end
    end
    rr_s1 = 1'b0; exp_armed = 1'b0; exp_g = 2'b00; cyc = 0;
    while (cyc < 3000 && !(si[0] == RND_BEATS && si[1] == RND_BEATS && grant == 2'b00)) begin
      for (int s = 0; s < 2; s++)
        if (!v[s] && si[s] < RND_BEATS && $urandom_range(0, 3) != 0) v[s] = 1'b1;
      j0 = (si[0] < RND_BEATS) ? si[0] : RND_BEATS - 1;
      j1 = (si[1] < RND_BEATS) ? si[1] : RND_BEATS - 1;
      s0_tvalid = v[0]; s0_tdata = rd[0][j0]; s0_tkeep = rk[0][j0]; s0_tlast = rl[0][j0];
      s1_tvalid = v[1]; s1_tdata = rd[1][j1]; s1_tkeep = rk[1][j1]; s1_tlast = rl[1][j1];
      m_tready = ($urandom_range(0, 2) != 0);
      #1;
      if (exp_armed) begin
        n_checks++;
        if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_arb_c%0d: grant=%b expected %b", cyc, grant, exp_g); end
        exp_armed = 1'b0;
      end
      if (!m_tvalid) begin
        n_checks++;
        if (m_tdata !== '0 || m_tkeep !== '0) begin n_fail++; $display("FAIL rnd_idle_zero_c%0d: dat=%h keep=%h expected 0/0", cyc, m_tdata, m_tkeep); end
      end
      if (grant == 2'b01 || grant == 2'b10) begin
        n_checks++;
        if ((grant[0] ? s0_tready : s1_tready) !== m_tready || (grant[0] ? s1_tready : s0_tready) !== 1'b0) begin
          n_fail++; $display("FAIL rnd_tready_c%0d: s0=%b s1=%b grant=%b m_tready=%b", cyc, s0_tready, s1_tready, grant, m_tready);
        end
      end
      if (grant == 2'b00) begin
        exp_armed = 1'b1;
        if (s0_tvalid && s1_tvalid) exp_g = rr_s1 ? 2'b10 : 2'b01;
        else if (s0_tvalid)         exp_g = 2'b01;
        else if (s1_tvalid)         exp_g = 2'b10;
        else                        exp_g = 2'b00;
      end
      if (m_tvalid && m_tready) begin
        n_checks++;
        if (grant != 2'b01 && grant != 2'b10) begin
          n_fail++; $display("FAIL rnd_owner_c%0d: beat with grant=%b expected one-hot", cyc, grant);
        end else begin
          o = grant[1] ? 1 : 0;
          if (ei[o] >= RND_BEATS) begin
            n_fail++; $display("FAIL rnd_extra_c%0d: s%0d beat %h beyond %0d sent", cyc, o, m_tdata, RND_BEATS);
          end else begin
            if ({m_tdata, m_tkeep, m_tlast} !== {rd[o][ei[o]], rk[o][ei[o]], rl[o][ei[o]]}) begin
              n_fail++; $display("FAIL rnd_beat_s%0d_%0d: got %h/%h/%b expected %h/%h/%b", o, ei[o],
                                 m_tdata, m_tkeep, m_tlast, rd[o][ei[o]], rk[o][ei[o]], rl[o][ei[o]]);
            end
            if (rl[o][ei[o]]) begin pkts[o]++; rr_s1 = (o == 0); end
            ei[o]++;
          end
        end
      end
      f0 = s0_tvalid & s0_tready; f1 = s1_tvalid & s1_tready;
      step();
      if (f0) begin si[0]++; v[0] = 1'b0; end
      if (f1) begin si[1]++; v[1] = 1'b0; end
      cyc++;
    end
    n_checks++; if (ei[0] != RND_BEATS || ei[1] != RND_BEATS) begin n_fail++; $display("FAIL rnd_delivered: s0=%0d s1=%0d expected %0d each (cycles %0d)", ei[0], ei[1], RND_BEATS, cyc); end
`ifdef SRIO_ARB_STATS_EN
    n_checks++; if (pkt_cnt0 !== 32'(pkts[0]) || pkt_cnt1 !== 32'(pkts[1])) begin n_fail++; $display("FAIL rnd_pkt_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1, pkts[0], pkts[1]); end
`endif
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_link_debounce();
    test_single();
    test_contention();
    test_backpressure();
    test_link_drop();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/srio_req_arbiter.md
SRIO_REQ_ARBITER -- requirements
Module: srio_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, ireq data width in bits (multiple of 8).
REQ-002 SHALL have parameter LINK_STABLE, default 16, cycles link status must hold high before link_up.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports port_initialized, link_initialized  input  1  SRIO core status, already in sys_clk domain.
REQ-006 SHALL have ports s0_tvalid/s1_tvalid  input  1  requester beat valid.
REQ-007 SHALL have ports s0_tready/s1_tready  output  1  requester beat accepted.
REQ-008 SHALL have ports s0_tdata/s1_tdata  input  DATA_W  requester beat data.
REQ-009 SHALL have ports s0_tkeep/s1_tkeep  input  DATA_W/8  requester byte enables.
REQ-010 SHALL have ports s0_tlast/s1_tlast  input  1  requester last beat of packet.
REQ-011 SHALL have ports m_tvalid, m_tdata, m_tkeep, m_tlast  output  1/DATA_W/DATA_W/8/1  SRIO ireq stream.
REQ-012 SHALL have port m_tready  input  1  SRIO ireq ready.
REQ-013 SHALL have port grant  output  2  one-hot current packet owner; 0 when none.
REQ-014 SHALL have port link_up  output  1  debounced link status.

Function
REQ-015 SHALL assert link_up after port_initialized & link_initialized held high LINK_STABLE consecutive cycles; SHALL deassert it the cycle after either input drops; any low cycle restarts the count.
REQ-016 SHALL implement states DOWN, IDLE, BUSY, FLUSH.
REQ-017 DOWN -> IDLE when link_up=1; all s*_tready=0, m_tvalid=0 in DOWN and IDLE.
REQ-018 IDLE with link_up: one requester valid -> grant it; both valid -> grant the one not granted last (round-robin pointer, reset value favours s0); registered grant, BUSY next cycle.
REQ-019 BUSY: m_t* = owner's s_t* combinationally; owner s_tready = m_tready; non-owner s_tready=0.
REQ-020 BUSY: beat with m_tvalid & m_tready & m_tlast -> IDLE next cycle, grant=0, pointer updated to owner; one-cycle bubble between packets is required.
REQ-021 BUSY with link_up falling -> FLUSH; in FLUSH m_tvalid=0, owner s_tready=1, beats discarded until owner tlast accepted, then DOWN.
REQ-022 IDLE with link_up falling -> DOWN; no grant issued in that cycle.
REQ-023 Non-owner held pending SHALL NOT lose its valid beat; it is granted next arbitration.
REQ-024 m_tdata/m_tkeep SHALL be zero whenever m_tvalid=0.

Reset
REQ-025 On sys_rst_n low: state DOWN, grant=0, link_up=0, debounce count 0, pointer=s0 next, m_tvalid=0, s*_tready=0, statistics 0; asserted mid-packet, packet is abandoned with no drain.

Configuration
REQ-026 With SRIO_ARB_STATS_EN defined, SHALL add outputs pkt_cnt0, pkt_cnt1 (32 bit, packets forwarded per requester) and flush_cnt (16 bit, FLUSH entries); all wrap at max; without the macro these ports and counters SHALL not exist, other behaviour identical.

Structure
REQ-027 SHALL place the state enum and LINK_STABLE default in shared package srio_arb_pkg.
REQ-028 SHALL implement the debounce of REQ-015 as sub-module srio_link_debounce.

Verification
REQ-029 Link rise: both status high at cycle 0 -> link_up=1 at cycle 16; status glitch low at cycle 10 -> count restarts.
REQ-030 Single requester: s0 sends 4-beat packet, m_tready=1 -> grant=01, 4 beats on m_t* bit-exact, tlast on beat 4, grant=0 next cycle.
REQ-031 Contention: s0 and s1 continuously valid, 2-beat packets -> grant order 01,10,01,10 with one idle cycle between.
REQ-032 Backpressure: m_tready toggles 1010 during 3-beat s1 packet -> no beat lost or duplicated, s1_tready mirrors m_tready.
REQ-033 Link drop at beat 2 of 5-beat packet -> m_tvalid=0 from drop, beats 3-5 consumed from s0, state DOWN, flush_cnt=1 (with SRIO_ARB_STATS_EN).
REQ-034 Reset asserted mid-packet -> all outputs to REQ-025 values asynchronously; after release and link_up, s1 packet granted normally.
